seg7_page_sched: RTL and testbench

Page scheduler and refresh controller for the 8-digit seven-segment display. It shares the display between up to four 32-bit debug sources, for example PC, instruction, register and memory data. It picks one source as the current page, either by dwell-time auto-rotation or by a debounced push button. It snapshots the selected word into the eight BCD/hex nibble inputs of the digit scanner and generates the scanner's refresh tick. It sits between the CPU debug taps and the multiplexed scan/decode block.

---
 rtl/seg7_ctrl_pkg.sv | 27 ++
 rtl/seg7_debounce.sv | 60 ++++++
 rtl/seg7_page_sched.sv | 165 ++++++++++++++++
 tb/tb_seg7_page_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_ctrl_pkg.sv
// Shared types and constants for the seven-segment page scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_ctrl_pkg;

    localparam int NSRC   = 4;
    localparam int WORD_W = 32;
    localparam int NIB_W  = 4;
    localparam int NDIG   = 8;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        SHOW = 2'd0,
        SEEK = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Word of source `sel`, or all zeros when that source may not be shown.
    function automatic logic [WORD_W-1:0] pick_word(
        input logic [NSRC*WORD_W-1:0] data,
        input logic [NSRC-1:0]        valid,
        input logic [SEL_W-1:0]       sel
    );
        pick_word = valid[sel] ? data[sel*WORD_W +: WORD_W] : '0;
    endfunction

endpackage

// File: rtl/seg7_debounce.sv
// Push-button conditioner: 2-flop synchronizer, scan-tick stability filter, rising-edge pulse.
// Latency: 2 clk of sync plus DEBOUNCE..DEBOUNCE+1 scan ticks from press to next_req.
// Backpressure: none; next_req is a fire-and-forget strobe.
module seg7_debounce #(
    parameter int DEBOUNCE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic tick,
    output logic next_req
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    assign differ = (sync2 != level);
    assign accept = tick && differ && (cnt == CW'(DEBOUNCE - 1));
    // The pulse coincides with the tick that flips the level, so it can
    // collide with a dwell expiry on the same tick.
    assign next_req = accept && !level;

    // Bring the raw asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive ticks of a differing level; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= accept ? '0 : cnt + 1'b1;
        end
    end

    // Accepted level flips once the disagreement has lasted long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
        end else if (accept) begin
            level <= ~level;
        end
    end

endmodule

// File: rtl/seg7_page_sched.sv
// Picks one of four debug words as the display page and snapshots it into eight scanner nibbles.
// Latency: request to new page/nibbles is 3 clk (first candidate valid) up to 5 clk (third).
// Backpressure: none; requests arriving while a page change is in flight are dropped.
module seg7_page_sched
    import seg7_ctrl_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DWELL_TICKS = 2000,
    parameter int DEBOUNCE    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] src_data,
    input  logic [3:0]   src_valid,
    input  logic         auto_en,
    input  logic         freeze,
    input  logic         btn_next,
    output logic         scan_tick,
    output logic [1:0]   page,
    output logic         page_valid,
    output logic         page_changed,
    output logic [3:0]   seg0,
    output logic [3:0]   seg1,
    output logic [3:0]   seg2,
    output logic [3:0]   seg3,
    output logic [3:0]   seg4,
    output logic [3:0]   seg5,
    output logic [3:0]   seg6,
    output logic [3:0]   seg7
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DW_W  = $clog2(DWELL_TICKS + 1);

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DW_W-1:0]   dwell_cnt;
    logic              dwell_exp;
    logic              next_req;
    logic [SEL_W-1:0]  cand;
    logic [1:0]        probe;
    logic [WORD_W-1:0] snap;
    logic              in_show;
    logic              start_seek;
    logic              probe_fail;
    logic              load_en;

    seg7_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn_next),
        .tick     (scan_tick),
        .next_req (next_req)
    );

    assign scan_tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // Free-running prescaler that defines the scan-tick grid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= scan_tick ? '0 : div_cnt + 1'b1;
        end
    end

    assign dwell_exp = in_show && auto_en && scan_tick
                    && (dwell_cnt == DW_W'(DWELL_TICKS - 1));

    // Dwell only accumulates while a page is on show in auto mode; leaving
    // SHOW (advance or failed search) restarts it from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (!auto_en || !in_show || dwell_exp) begin
            dwell_cnt <= '0;
        end else if (scan_tick) begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SHOW;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: at most three candidates are probed after the current page.
    always_comb begin
        state_nxt = state;
        case (state)
            SHOW: if (next_req || dwell_exp) state_nxt = SEEK;
            SEEK: begin
                if (src_valid[cand])     state_nxt = LOAD;
                else if (probe == 2'd2)  state_nxt = SHOW;
            end
            LOAD:    state_nxt = SHOW;
            default: state_nxt = SHOW;
        endcase
    end

    // FSM outputs: strobes steering the candidate, page and snapshot registers.
    always_comb begin
        in_show    = (state == SHOW);
        start_seek = (state == SHOW) && (next_req || dwell_exp);
        probe_fail = (state == SEEK) && !src_valid[cand];
        load_en    = (state == LOAD);
    end

    // Candidate walk; cand never wraps back to the current page within three probes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand  <= '0;
            probe <= '0;
        end else if (start_seek) begin
            cand  <= page + 2'd1;
            probe <= '0;
        end else if (probe_fail) begin
            cand  <= cand + 2'd1;
            probe <= probe + 2'd1;
        end
    end

    // Current page, its change strobe and its registered validity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page         <= '0;
            page_changed <= 1'b0;
            page_valid   <= 1'b0;
        end else begin
            if (load_en) page <= cand;
            page_changed <= load_en;
            page_valid   <= src_valid[page];
        end
    end

    // Snapshot: immediate on a page load, otherwise refreshed per scan tick; freeze holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (!freeze) begin
            if (load_en) begin
                snap <= pick_word(src_data, src_valid, cand);
            end else if (in_show && scan_tick) begin
                snap <= pick_word(src_data, src_valid, page);
            end
        end
    end

    assign seg0 = snap[31:28];
    assign seg1 = snap[27:24];
    assign seg2 = snap[23:20];
    assign seg3 = snap[19:16];
    assign seg4 = snap[15:12];
    assign seg5 = snap[11:8];
    assign seg6 = snap[7:4];
    assign seg7 = snap[3:0];

endmodule

// File: tb/tb_seg7_page_sched.sv
// Directed bench for seg7_page_sched with small prescaler/dwell/debounce settings.
// Latency: checks 3 and 5 clk page-change latency from the expiring scan tick.
// Backpressure: n/a.
module tb_seg7_page_sched;
    import seg7_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] src_data;
    logic [3:0]   src_valid;
    logic         auto_en;
    logic         freeze;
    logic         btn_next;
    logic         scan_tick;
    logic [1:0]   page;
    logic         page_valid;
    logic         page_changed;
    logic [3:0]   seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int changes = 0;

    seg7_page_sched #(
        .SCAN_DIV    (4),
        .DWELL_TICKS (3),
        .DEBOUNCE    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .auto_en      (auto_en),
        .freeze       (freeze),
        .btn_next     (btn_next),
        .scan_tick    (scan_tick),
        .page         (page),
        .page_valid   (page_valid),
        .page_changed (page_changed),
        .seg0         (seg0),
        .seg1         (seg1),
        .seg2         (seg2),
        .seg3         (seg3),
        .seg4         (seg4),
        .seg5         (seg5),
        .seg6         (seg6),
        .seg7         (seg7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] segw();
        return {seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7};
    endfunction

    // One clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (page_changed) changes++;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!scan_tick && n < 20);
        if (!scan_tick) check("tick_timeout", 32'(scan_tick), 32'd1);
    endtask

    task automatic wait_change(input int budget, output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!page_changed && waited < budget);
        if (!page_changed) check("chg_timeout", 32'(page_changed), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press();
        btn_next = 1'b1;
        run(13);
        btn_next = 1'b0;
        run(30);
    endtask

    // Start auto mode just after a tick so the third following tick expires the dwell.
    task automatic arm_dwell(output int kx);
        wait_tick();
        step();
        auto_en = 1'b1;
        wait_tick();
        wait_tick();
        wait_tick();
        kx = cyc;
    endtask

    initial begin
        int w;
        int kx;
        int c0;
        logic [31:0] expw [4];

        rst_n     = 1'b0;
        src_data  = {32'h0F1E2D3C, 32'hDEADBEEF, 32'hCAFE0001, 32'h1234ABCD};
        src_valid = 4'b1111;
        auto_en   = 1'b0;
        freeze    = 1'b0;
        btn_next  = 1'b0;

        // Reset values
        run(3);
        check("rst_page", 32'(page), 32'd0);
        check("rst_pvld", 32'(page_valid), 32'd0);
        check("rst_pchg", 32'(page_changed), 32'd0);
        check("rst_tick", 32'(scan_tick), 32'd0);
        check("rst_segs", segw(), 32'h0);

        // Prescaler: tick on the 4th cycle after release, nibbles load on it
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pre_tick", 32'(scan_tick), (i == 3) ? 32'd1 : 32'd0);
            check("pre_segs", segw(), 32'h0);
            if (i < 3) step();
        end
        step();
        check("first_snap", segw(), 32'h1234ABCD);
        check("seg0", 32'(seg0), 32'h1);
        check("seg7", 32'(seg7), 32'hD);
        check("pvld_p0", 32'(page_valid), 32'd1);
        c0 = cyc;
        wait_tick();
        check("tick_period", 32'(cyc - c0), 32'd3);
        c0 = cyc;
        wait_tick();
        check("tick_period2", 32'(cyc - c0), 32'd4);

        // Auto rotation 0->1->2->3->0, 12 clocks apart on the free-running tick grid
        auto_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_change(60, w);
            if (i == 3) auto_en = 1'b0;
            check("rot_page", 32'(page), 32'((i + 1) % 4));
            if (i > 0) check("rot_period", 32'(w), 32'd12);
            if (i == 0) check("rot_snap1", segw(), 32'hCAFE0001);
        end
        step();
        check("pchg_width", 32'(page_changed), 32'd0);

        // Skip invalid: 1001 from page 0 probes 1,2 then loads 3, 5 clocks after expiry
        src_valid = 4'b1001;
        arm_dwell(kx);
        wait_change(20, w);
        auto_en = 1'b0;
        check("skip_lat", 32'(cyc - kx), 32'd5);
        check("skip_page", 32'(page), 32'd3);
        check("skip_snap", segw(), 32'h0F1E2D3C);
        step();
        check("skip_pvld", 32'(page_valid), 32'd1);

        // Button from page 3 wraps to page 0
        c0 = changes;
        press();
        check("btn_wrap_n", 32'(changes - c0), 32'd1);
        check("btn_wrap_pg", 32'(page), 32'd0);

        // Only page 0 valid: search fails, no change
        src_valid = 4'b0001;
        c0 = changes;
        press();
        check("nofind_n", 32'(changes - c0), 32'd0);
        check("nofind_pg", 32'(page), 32'd0);

        // Current page invalid: snapshot shows zeros, page_valid drops
        src_valid = 4'b1110;
        wait_tick();
        step();
        check("inv_segs", segw(), 32'h0);
        check("inv_pvld", 32'(page_valid), 32'd0);
        check("inv_page", 32'(page), 32'd0);
        src_valid = 4'b1111;

        // Debounce: one-tick glitch ignored
        c0 = changes;
        btn_next = 1'b1;
        run(3);
        btn_next = 1'b0;
        run(40);
        check("glitch_n", 32'(changes - c0), 32'd0);

        // Long press with a bounce on release: exactly one advance
        c0 = changes;
        btn_next = 1'b1;
        run(13);
        btn_next = 1'b0;
        run(2);
        btn_next = 1'b1;
        run(2);
        btn_next = 1'b0;
        run(40);
        check("press_n", 32'(changes - c0), 32'd1);
        check("press_pg", 32'(page), 32'd1);

        // Freeze: nibbles hold while page still advances; release refreshes on next tick
        wait_tick();
        step();
        check("pre_frz", segw(), 32'hCAFE0001);
        freeze = 1'b1;
        expw[0] = 32'h89ABCDEF;
        expw[1] = 32'h13579BDF;
        expw[2] = 32'h2468ACE0;
        expw[3] = 32'h55AA33CC;
        src_data = {expw[3], expw[2], expw[1], expw[0]};
        c0 = changes;
        press();
        check("frz_n", 32'(changes - c0), 32'd1);
        check("frz_page", 32'(page), 32'd2);
        check("frz_segs", segw(), 32'hCAFE0001);
        freeze = 1'b0;
        wait_tick();
        step();
        check("unfrz_segs", segw(), expw[2]);

        // Collision: button pulse on the dwell-expiry tick gives a single step
        c0 = changes;
        wait_tick();
        step();
        auto_en = 1'b1;
        wait_tick();
        btn_next = 1'b1;
        wait_change(20, w);
        auto_en = 1'b0;
        check("coll_lat", 32'(w), 32'd11);
        btn_next = 1'b0;
        run(40);
        check("coll_n", 32'(changes - c0), 32'd1);
        check("coll_page", 32'(page), 32'd3);

        // Reset asserted mid-SEEK: only source 3 valid so the search runs 3 cycles
        src_valid = 4'b1000;
        wait_tick();
        step();
        check("pre_rst_segs", segw(), expw[3]);
        arm_dwell(kx);
        run(2);
        check("in_seek", 32'(dut.state), 32'(SEEK));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_page", 32'(page), 32'd0);
        check("arst_segs", segw(), 32'h0);
        check("arst_pvld", 32'(page_valid), 32'd0);
        check("arst_pchg", 32'(page_changed), 32'd0);
        check("arst_tick", 32'(scan_tick), 32'd0);
        check("arst_state", 32'(dut.state), 32'(SHOW));
        auto_en = 1'b0;
        run(2);
        rst_n = 1'b1;
        c0 = changes;
        run(20);
        check("post_rst_n", 32'(changes - c0), 32'd0);
        check("post_rst_pg", 32'(page), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
